// File: rtl/spectrum_avg.sv
// -----------------------------------------------------------------------------
// spectrum_avg
//
// Purpose:
//   Averages 2^AVG_POW2 consecutive FFT power frames bin by bin. Incoming bins
//   are summed into a FRAME_WORDS-deep accumulator. When a full averaging set
//   has arrived, the averaged frame is streamed out (sum >> AVG_POW2) before
//   any new input is accepted.
//
// Parameters:
//   FRAME_WORDS  power bins per frame (power of 2, >= 4)
//   DATA_W       input/output power word width
//   AVG_POW2     log2 of the number of frames averaged (1..4)
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   s_axis_tdata   unsigned power bin in
//   s_axis_tvalid  input valid
//   s_axis_tlast   marks the final bin of an input frame
//   s_axis_tready  high while accumulating
//   m_axis_tdata   averaged power bin out (zero when not valid)
//   m_axis_tvalid  high while draining
//   m_axis_tlast   high on the final averaged bin
//   m_axis_tready  downstream ready
//   frame_err      one-cycle pulse when frame length and tlast disagree
//   peak_idx       index of the largest averaged bin of the last drained frame
//   peak_valid     one-cycle pulse after the last output handshake
//   o_dbg_state    current state (0 = ACCUM, 1 = DRAIN)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. Valid never depends on ready; while valid is high and ready is low the
// data and last signals hold their value.
//
// Optional feature: define SPECTRUM_AVG_PEAK_EN to build the peak-bin tracker.
// Without it peak_idx and peak_valid are constant 0.
// -----------------------------------------------------------------------------
module spectrum_avg #(
   parameter int FRAME_WORDS = 256,
   parameter int DATA_W      = 32,
   parameter int AVG_POW2    = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_W-1:0]              s_axis_tdata,
   input  logic                           s_axis_tvalid,
   input  logic                           s_axis_tlast,
   output logic                           s_axis_tready,
   output logic [DATA_W-1:0]              m_axis_tdata,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   output logic                           frame_err,
   output logic [$clog2(FRAME_WORDS)-1:0] peak_idx,
   output logic                           peak_valid,
   output logic                           o_dbg_state
);

   localparam int IDX_W = $clog2(FRAME_WORDS);
   // Summing 2^AVG_POW2 words of DATA_W bits needs AVG_POW2 extra bits.
   localparam int ACC_W = DATA_W + AVG_POW2;
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(FRAME_WORDS - 1);
   localparam logic [AVG_POW2-1:0] LAST_FRAME = '1;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_wr_idx;
   logic [IDX_W-1:0]    r_rd_idx;
   logic [AVG_POW2-1:0] r_frame_cnt;
   logic                r_frame_err;
   logic [ACC_W-1:0]    r_acc [FRAME_WORDS];

   logic                w_in_hs;
   logic                w_out_hs;
   logic [ACC_W-1:0]    w_acc_wr_data;
   logic [ACC_W-1:0]    w_acc_rd;
   logic [DATA_W-1:0]   w_avg_word;

   assign w_in_hs  = (r_state == ST_ACCUM) && s_axis_tvalid;
   assign w_out_hs = (r_state == ST_DRAIN) && m_axis_tready;

   // The first frame of a set overwrites whatever the entry held, so the
   // accumulator never needs clearing (after reset or a discarded set).
   assign w_acc_wr_data = (r_frame_cnt == '0)
                        ? ACC_W'(s_axis_tdata)
                        : r_acc[r_wr_idx] + ACC_W'(s_axis_tdata);

   assign w_acc_rd   = r_acc[r_rd_idx];
   assign w_avg_word = DATA_W'(w_acc_rd >> AVG_POW2);

   // Outputs are decoded from registered state only; rd_idx moves only on an
   // output handshake, so data/last hold steady during a stall.
   assign s_axis_tready = (r_state == ST_ACCUM);
   assign m_axis_tvalid = (r_state == ST_DRAIN);
   assign m_axis_tdata  = (r_state == ST_DRAIN) ? w_avg_word : '0;
   assign m_axis_tlast  = (r_state == ST_DRAIN) && (r_rd_idx == LAST_IDX);
   assign frame_err     = r_frame_err;
   assign o_dbg_state   = r_state;

   // Accumulator storage: no reset, contents are don't-care until overwritten.
   always_ff @(posedge clk) begin
      if (!rst && w_in_hs) begin
         r_acc[r_wr_idx] <= w_acc_wr_data;
      end
   end

   // Control FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_ACCUM;
         r_wr_idx    <= '0;
         r_rd_idx    <= '0;
         r_frame_cnt <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            ST_ACCUM: begin
               if (w_in_hs) begin
                  if (r_wr_idx == LAST_IDX) begin
                     // Full-length frame: kept even if tlast is missing.
                     r_wr_idx <= '0;
                     if (!s_axis_tlast) begin
                        r_frame_err <= 1'b1;
                     end
                     if (r_frame_cnt == LAST_FRAME) begin
                        r_state     <= ST_DRAIN;
                        r_rd_idx    <= '0;
                        r_frame_cnt <= '0;
                     end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                     end
                  end else if (s_axis_tlast) begin
                     // Short frame: the whole averaging set is discarded.
                     r_wr_idx    <= '0;
                     r_frame_cnt <= '0;
                     r_frame_err <= 1'b1;
                  end else begin
                     r_wr_idx <= r_wr_idx + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_out_hs) begin
                  if (r_rd_idx == LAST_IDX) begin
                     r_state  <= ST_ACCUM;
                     r_rd_idx <= '0;
                  end else begin
                     r_rd_idx <= r_rd_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_ACCUM;
            end
         endcase
      end
   end

`ifdef SPECTRUM_AVG_PEAK_EN
   logic [DATA_W-1:0] r_peak_best;
   logic [IDX_W-1:0]  r_peak_best_idx;
   logic [IDX_W-1:0]  r_peak_idx;
   logic              r_peak_valid;
   logic              w_peak_take;

   // Strict greater-than keeps the lowest index on ties; bin 0 always seeds
   // the search so stale values from an abandoned drain never leak in.
   assign w_peak_take = (r_rd_idx == '0) || (w_avg_word > r_peak_best);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_peak_best     <= '0;
         r_peak_best_idx <= '0;
         r_peak_idx      <= '0;
         r_peak_valid    <= 1'b0;
      end else begin
         r_peak_valid <= 1'b0;
         if (w_out_hs) begin
            if (w_peak_take) begin
               r_peak_best     <= w_avg_word;
               r_peak_best_idx <= r_rd_idx;
            end
            if (r_rd_idx == LAST_IDX) begin
               r_peak_valid <= 1'b1;
               r_peak_idx   <= w_peak_take ? r_rd_idx : r_peak_best_idx;
            end
         end
      end
   end

   assign peak_idx   = r_peak_idx;
   assign peak_valid = r_peak_valid;
`else
   assign peak_idx   = '0;
   assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spectrum_avg.sv
// -----------------------------------------------------------------------------
// tb_spectrum_avg
//
// Bench for spectrum_avg at FRAME_WORDS=256, DATA_W=32, AVG_POW2=2.
// A reference model collects accepted input frames into averaging sets and
// predicts each averaged frame as the floored mean of its bins; a negedge
// monitor compares every output beat, stall stability, latency, frame_err
// pulses and the peak report. Compile with +define+SPECTRUM_AVG_PEAK_EN to
// check the peak tracker.
// -----------------------------------------------------------------------------
module tb_spectrum_avg;

   localparam int FW = 256;
   localparam int DW = 32;
   localparam int AP = 2;
   localparam int NF = 4;
   localparam int IW = 8;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   int            cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;
   logic          frame_err;
   logic [IW-1:0] peak_idx;
   logic          peak_valid;
   logic          o_dbg_state;

   spectrum_avg #(.FRAME_WORDS(FW), .DATA_W(DW), .AVG_POW2(AP)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .frame_err     (frame_err),
      .peak_idx      (peak_idx),
      .peak_valid    (peak_valid),
      .o_dbg_state   (o_dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   int            peak_q[$];
   logic [DW-1:0] cur_q[$];
   logic [DW-1:0] set_buf [NF][FW];
   int            set_n = 0;
   int            err_exp = 0;
   int            err_seen = 0;
   int            peak_seen = 0;
   bit            gaps = 1'b0;
   bit            rnd_ready = 1'b0;
   int            out_set_cnt = 0;
   int            drain_cycles = 0;
   bit            lat_pending = 1'b0;
   int            lat_cyc = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   bit            prev_err = 1'b0;
   bit            prev_pv = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Called once per accepted input beat.
   task automatic model_beat(input logic [DW-1:0] d, input logic l);
      logic [63:0]   sum;
      logic [DW-1:0] avg;
      logic [DW-1:0] best;
      int            best_i;
      cur_q.push_back(d);
      if (cur_q.size() == FW) begin
         if (!l) err_exp++;
         for (int i = 0; i < FW; i++) set_buf[set_n][i] = cur_q[i];
         cur_q.delete();
         set_n++;
         if (set_n == NF) begin
            best   = '0;
            best_i = 0;
            for (int i = 0; i < FW; i++) begin
               sum = '0;
               for (int k = 0; k < NF; k++) sum += 64'(set_buf[k][i]);
               avg = DW'(sum / NF);
               exp_q.push_back(avg);
               if (i == 0 || avg > best) begin
                  best   = avg;
                  best_i = i;
               end
            end
`ifdef SPECTRUM_AVG_PEAK_EN
            peak_q.push_back(best_i);
`endif
            set_n       = 0;
            lat_pending = 1'b1;
            lat_cyc     = cyc;
         end
      end else if (l) begin
         err_exp++;
         cur_q.delete();
         set_n = 0;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         prev_stall   = 1'b0;
         prev_err     = 1'b0;
         prev_pv      = 1'b0;
         out_set_cnt  = 0;
         drain_cycles = 0;
      end else begin
         if (lat_pending && cyc == lat_cyc + 1) begin
            check("first_out_latency", 64'(m_axis_tvalid), 64'd1);
            lat_pending = 1'b0;
         end
         if (prev_stall) begin
            check("stall_valid", 64'(m_axis_tvalid), 64'd1);
            check("stall_data", 64'(m_axis_tdata), 64'(prev_data));
            check("stall_last", 64'(m_axis_tlast), 64'(prev_last));
         end
         if (m_axis_tvalid) begin
            check("in_ready_in_drain", 64'(s_axis_tready), 64'd0);
            drain_cycles++;
            if (m_axis_tready) begin
               if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
               else check("out_data", 64'(m_axis_tdata), 64'(exp_q.pop_front()));
               check("out_last", 64'(m_axis_tlast), 64'(out_set_cnt == FW - 1));
               if (out_set_cnt == FW - 1) begin
                  if (!rnd_ready) check("drain_cycles", 64'(drain_cycles), 64'(FW));
                  out_set_cnt  = 0;
                  drain_cycles = 0;
               end else begin
                  out_set_cnt++;
               end
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         if (frame_err) begin
            err_seen++;
            check("err_pulse_width", 64'(prev_err), 64'd0);
         end
         prev_err = frame_err;
         if (peak_valid) begin
            peak_seen++;
            check("peak_pulse_width", 64'(prev_pv), 64'd0);
`ifdef SPECTRUM_AVG_PEAK_EN
            if (peak_q.size() == 0) check("peak_unexpected", 64'd1, 64'd0);
            else check("peak_idx", 64'(peak_idx), 64'(peak_q.pop_front()));
`endif
         end
         prev_pv = peak_valid;
      end
   end

   // ---------------- drivers ----------------
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int t = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         s_axis_tvalid = 1'b0;
         @(posedge clk);
         #1;
      end
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_axis_tready) begin
            model_beat(d, l);
            break;
         end
         t++;
         if (t > 5000) begin
            check("in_ready_timeout", 64'd1, 64'd0);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // kind: 0 constant, 1 ramp i+f, 2 random, 3 constant with spike at bin 37
   task automatic send_frame(input int kind, input int f, input logic [DW-1:0] val,
                             input int len, input bit give_last);
      logic [DW-1:0] d;
      for (int i = 0; i < len; i++) begin
         case (kind)
            0:       d = val;
            1:       d = DW'(i + f);
            2:       d = $urandom;
            default: d = (i == 37) ? DW'(4000) : val;
         endcase
         send_beat(d, give_last && (i == len - 1));
      end
   endtask

   task automatic send_set(input int kind, input logic [DW-1:0] val);
      for (int f = 0; f < NF; f++) send_frame(kind, f, val, FW, 1'b1);
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || peak_q.size() != 0) && t < 4000) begin
         @(posedge clk);
         t++;
      end
      check("drain_finished", 64'(exp_q.size() + peak_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic checkpoint(input string tag);
      check({tag, "_err_count"}, 64'(err_seen), 64'(err_exp));
`ifndef SPECTRUM_AVG_PEAK_EN
      check({tag, "_peak_pulses"}, 64'(peak_seen), 64'd0);
      check({tag, "_peak_idx"}, 64'(peak_idx), 64'd0);
`endif
   endtask

   initial begin
      #3000000;
      check("watchdog", 64'd1, 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int t;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd1);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_peak_valid", 64'(peak_valid), 64'd0);
      check("rst_peak_idx", 64'(peak_idx), 64'd0);
      check("rst_state", 64'(o_dbg_state), 64'd0);
      @(posedge clk);
      #1;

      // Constant 100 in every bin.
      send_set(0, DW'(100));
      wait_drain();
      checkpoint("const100");

      // Ramp: frame f bin i = i+f, averaged bin i = i+1.
      send_set(1, '0);
      wait_drain();
      checkpoint("ramp");

      // Full-scale words must not overflow.
      send_set(0, 32'hFFFF_FFFF);
      wait_drain();
      checkpoint("full_scale");

      // Random data, input gaps, random output backpressure, one frame whose
      // tlast is missing (kept, but flagged).
      gaps      = 1'b1;
      rnd_ready = 1'b1;
      send_frame(2, 0, '0, FW, 1'b1);
      send_frame(2, 1, '0, FW, 1'b0);
      send_frame(2, 2, '0, FW, 1'b1);
      send_frame(2, 3, '0, FW, 1'b1);
      wait_drain();
      gaps      = 1'b0;
      rnd_ready = 1'b0;
      checkpoint("random_stall");

      // Early tlast on bin 10 of the third frame discards the set.
      send_frame(0, 0, DW'(5), FW, 1'b1);
      send_frame(0, 1, DW'(5), FW, 1'b1);
      send_frame(0, 2, DW'(5), 11, 1'b1);
      send_set(0, DW'(7));
      wait_drain();
      checkpoint("short_frame");

      // Reset in the middle of a drain, then a clean set with a spike.
      send_set(2, '0);
      t = 0;
      while (out_set_cnt < 50 && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("reach_word50", 64'(out_set_cnt >= 50), 64'd1);
      rst = 1'b1;
      exp_q.delete();
      peak_q.delete();
      cur_q.delete();
      set_n       = 0;
      lat_pending = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("midrst_s_tready", 64'(s_axis_tready), 64'd1);
      check("midrst_m_tdata", 64'(m_axis_tdata), 64'd0);
      @(posedge clk);
      #1;
      send_set(3, DW'(9));
      wait_drain();
      checkpoint("after_reset");
`ifdef SPECTRUM_AVG_PEAK_EN
      check("peak_pulse_total", 64'(peak_seen), 64'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spectrum_avg.md
SPECTRUM_AVG -- requirements
Module: spectrum_avg

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 256, meaning power bins per FFT frame (power of 2, >=4).
REQ-002 SHALL have parameter DATA_W, default 32, meaning input/output power word width.
REQ-003 SHALL have parameter AVG_POW2, default 2, meaning log2 of frames averaged (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_axis_tdata  input  DATA_W  unsigned power bin from the FFT power path.
REQ-007 SHALL have ports s_axis_tvalid input 1, s_axis_tlast input 1, s_axis_tready output 1  input AXI-stream handshake; tlast marks the frame's final bin.
REQ-008 SHALL have port m_axis_tdata  output  DATA_W  averaged power bin, to packet_gen.
REQ-009 SHALL have ports m_axis_tvalid output 1, m_axis_tlast output 1, m_axis_tready input 1  output AXI-stream handshake.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on frame length/tlast mismatch.
REQ-011 SHALL have ports peak_idx output $clog2(FRAME_WORDS) and peak_valid output 1  peak bin report (see Configuration).

Function
REQ-012 SHALL use accumulator storage of FRAME_WORDS entries, ACC_W = DATA_W+AVG_POW2 bits each; no overflow is possible.
REQ-013 SHALL implement two states: ACCUM and DRAIN.
REQ-014 In ACCUM, s_axis_tready SHALL be 1 and m_axis_tvalid SHALL be 0.
REQ-015 On each ACCUM input handshake, entry[wr_idx] SHALL become tdata if frame_cnt==0, else entry[wr_idx]+tdata; wr_idx then increments.
REQ-016 A handshake with wr_idx==FRAME_WORDS-1 SHALL end the frame: wr_idx->0, frame_cnt increments; if tlast is 0 frame_err pulses the next cycle but the frame is kept.
REQ-017 A handshake with tlast=1 and wr_idx<FRAME_WORDS-1 SHALL pulse frame_err next cycle and set wr_idx=0, frame_cnt=0 (whole averaging set discarded).
REQ-018 When the frame ending per REQ-016 has frame_cnt==2^AVG_POW2-1, state SHALL go to DRAIN the next cycle with rd_idx=0, frame_cnt=0.
REQ-019 In DRAIN, s_axis_tready SHALL be 0, m_axis_tvalid SHALL be 1, m_axis_tdata SHALL equal entry[rd_idx]>>AVG_POW2 (floor, low DATA_W bits), m_axis_tlast SHALL be 1 iff rd_idx==FRAME_WORDS-1.
REQ-020 m_axis_tdata/tlast SHALL stay stable while tvalid=1 and tready=0; rd_idx advances only on handshake.
REQ-021 The last output handshake SHALL return state to ACCUM the next cycle; s_axis_tready rises that cycle.
REQ-022 Latency: first averaged word valid exactly 1 cycle after the final input handshake of the set; with m_axis_tready held 1, a frame drains in FRAME_WORDS cycles.

Reset
REQ-023 On rst=1 at a clock edge: state=ACCUM, wr_idx=rd_idx=frame_cnt=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_err=0, peak_valid=0, peak_idx=0; s_axis_tready=1 from the first cycle after reset.
REQ-024 Reset mid-ACCUM or mid-DRAIN SHALL abandon all partial data; accumulator contents need not be cleared (frame_cnt==0 overwrite rule covers it).

Configuration
REQ-025 Macro SPECTRUM_AVG_PEAK_EN: when defined, DRAIN SHALL track the largest output word (lowest index wins ties); peak_idx/peak_valid SHALL be driven for one cycle following the last output handshake.
REQ-026 Without SPECTRUM_AVG_PEAK_EN, peak_idx and peak_valid SHALL be tied to 0 and no compare logic generated.

Verification (FRAME_WORDS=256, DATA_W=32, AVG_POW2=2)
REQ-027 4 frames, all bins 100, tready=1 -> 256 outputs of 100, tlast only on word 255, s_axis_tready 0 during DRAIN.
REQ-028 frame f (0..3), bin i = i+f -> output bin i = i+1 (sum 4i+6, floored /4).
REQ-029 all bins 0xFFFFFFFF for 4 frames -> every output 0xFFFFFFFF, no overflow.
REQ-030 random m_axis_tready (50%) during DRAIN -> 256 words, no loss/duplication, data stable while stalled.
REQ-031 tlast on bin 10 of frame 2 -> frame_err single pulse; following 4 clean frames of 7 -> outputs all 7.
REQ-032 rst at output word 50 -> m_axis_tvalid=0 next cycle, s_axis_tready=1; next 4 frames of 9 -> outputs 9; with SPECTRUM_AVG_PEAK_EN and a spike of 4000 in bin 37 of each frame -> peak_idx=37, peak_valid one pulse.
